// File: rtl/memory_turn_ctrl.sv
// memory_turn_ctrl: turn sequencer for the two-player card-matching game.
// Accepts debounced picks, reads card values from the board store, compares
// pairs, tracks revealed/matched masks, scores, turn ownership and winner.
// Optional build macro: TURN_TIMEOUT_EN (forces a turn change after
// TURN_CYCLES cycles spent in PICK1/PICK2).
module memory_turn_ctrl #(
  parameter int unsigned SHOW_CYCLES = 50000000,
  parameter int unsigned TURN_CYCLES = 500000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        btn_select,
  input  logic [3:0]  sel_idx,
  input  logic [3:0]  card_val,
  output logic [3:0]  card_addr,
  output logic        player,
  output logic [3:0]  score0,
  output logic [3:0]  score1,
  output logic [15:0] revealed,
  output logic [15:0] matched,
  output logic        match_pulse,
  output logic        game_over,
  output logic [1:0]  winner
);

  typedef enum logic [2:0] {
    IDLE, PICK1, PICK2, COMPARE, SHOW, CHECK, DONE
  } state_t;

  state_t      state, stateNext;
  logic [3:0]  idx1, idx2, val1, val2, lastIdx;
  logic [31:0] showCnt;
  logic        newGame, acceptPick1, acceptPick2, isMatch, showDone;
  logic        expired, timeoutFire;
`ifdef TURN_TIMEOUT_EN
  logic [31:0] turnCnt;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state decode, event strobes and combinational outputs
  always_comb begin
    stateNext   = state;
    newGame     = 1'b0;
    acceptPick1 = 1'b0;
    acceptPick2 = 1'b0;
    isMatch     = 1'b0;
    showDone    = 1'b0;
    timeoutFire = 1'b0;
    expired     = 1'b0;
`ifdef TURN_TIMEOUT_EN
    expired = (state == PICK1 || state == PICK2) && (turnCnt == '0);
`endif
    case (state)
      IDLE, DONE: begin
        if (start) begin
          newGame   = 1'b1;
          stateNext = PICK1;
        end
      end
      PICK1: begin
        if (expired) begin
          timeoutFire = 1'b1;
          stateNext   = PICK1;
        end else if (btn_select && !matched[sel_idx]) begin
          acceptPick1 = 1'b1;
          stateNext   = PICK2;
        end
      end
      PICK2: begin
        // an accepted second pick takes priority over a coincident timeout
        if (btn_select && !matched[sel_idx] && sel_idx != idx1) begin
          acceptPick2 = 1'b1;
          stateNext   = COMPARE;
        end else if (expired) begin
          timeoutFire = 1'b1;
          stateNext   = PICK1;
        end
      end
      COMPARE: begin
        isMatch   = (val1 == val2);
        stateNext = isMatch ? CHECK : SHOW;
      end
      SHOW: begin
        if (showCnt == '0) begin
          showDone  = 1'b1;
          stateNext = PICK1;
        end
      end
      CHECK: stateNext = (matched == '1) ? DONE : PICK1;
      default: stateNext = IDLE;
    endcase

    card_addr = (state == PICK1 || state == PICK2) ? sel_idx : lastIdx;
    game_over = (state == DONE);
    winner    = 2'b00;
    if (state == DONE) begin
      if (score0 > score1)      winner = 2'b01;
      else if (score0 < score1) winner = 2'b10;
      else                      winner = 2'b11;
    end
  end

  // Game datapath: picks, masks, scores, turn owner, reveal timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx1        <= '0;
      idx2        <= '0;
      val1        <= '0;
      val2        <= '0;
      lastIdx     <= '0;
      player      <= 1'b0;
      score0      <= '0;
      score1      <= '0;
      revealed    <= '0;
      matched     <= '0;
      match_pulse <= 1'b0;
      showCnt     <= '0;
    end else begin
      match_pulse <= isMatch;
      if (newGame) begin
        player   <= 1'b0;
        score0   <= '0;
        score1   <= '0;
        revealed <= '0;
        matched  <= '0;
      end
      if (acceptPick1) begin
        idx1              <= sel_idx;
        val1              <= card_val;
        lastIdx           <= sel_idx;
        revealed[sel_idx] <= 1'b1;
      end
      if (acceptPick2) begin
        idx2              <= sel_idx;
        val2              <= card_val;
        lastIdx           <= sel_idx;
        revealed[sel_idx] <= 1'b1;
      end
      if (isMatch) begin
        matched[idx1] <= 1'b1;
        matched[idx2] <= 1'b1;
        if (player) score1 <= score1 + 4'd1;
        else        score0 <= score0 + 4'd1;
      end
      if (state == COMPARE)
        showCnt <= SHOW_CYCLES - 1;
      else if (state == SHOW && showCnt != '0)
        showCnt <= showCnt - 32'd1;
      if (showDone) begin
        revealed[idx1] <= 1'b0;
        revealed[idx2] <= 1'b0;
        player         <= ~player;
      end
      // only the current turn's picks can be face-up and unmatched here
      if (timeoutFire) begin
        revealed <= matched;
        player   <= ~player;
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  // Turn timer: reload on every entry to PICK1, count down while picking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      turnCnt <= '0;
    else if (stateNext == PICK1 && (state != PICK1 || timeoutFire))
      turnCnt <= TURN_CYCLES - 1;
    else if ((state == PICK1 || state == PICK2) && turnCnt != '0)
      turnCnt <= turnCnt - 32'd1;
  end
`endif

endmodule
